spi_pkt_tx: RTL
===============

# spi_pkt_tx

SPI master transmitter that drains one full packet from the packet buffer and shifts it to the WiFi module. Sits directly downstream of the packet buffer in the read-clock domain: issues single-cycle read strobes, captures each byte when the buffer flags it valid, and serialises it MSB-first in SPI mode 0. Optionally prefixes each packet with a sync/sequence header.

## Interface
Parameters:
- DATA_WIDTH, 8, buffer word width (fixed at 8 for SPI byte framing)
- PKT_BYTES, 60, payload bytes per packet (must equal buffer depth)
- CNT_WIDTH, 14, byte-counter width; must satisfy 2^CNT_WIDTH > PKT_BYTES
- CLK_DIV, 4, clk cycles per SCLK half-period, ≥2
- CS_GAP, 8, minimum clk cycles spi_cs_n stays high between packets

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  block clock (buffer read clock)
- rst  in  1  synchronous active-high reset
- pkt_start  in  1  single-cycle pulse: buffer holds a complete packet
- buf_rd_en  out  1  read strobe to buffer, one cycle per byte
- buf_dout  in  8  buffer read data
- buf_valid  in  1  buf_dout valid (arrives 2 cycles after buf_rd_en)
- buf_rd_out  in  1  buffer reports all PKT_BYTES consumed
- spi_sclk  out  1  SPI clock, idle low
- spi_cs_n  out  1  chip select, active low
- spi_mosi  out  1  serial data
- busy  out  1  packet in progress
- pkt_done  out  1  single-cycle pulse after successful packet
- pkt_err  out  1  single-cycle pulse on underrun abort

## Operation
- States: IDLE, CS_SETUP, HDR, FETCH, WAIT_VLD, SHIFT, CS_HOLD, GAP.
- IDLE: pkt_start → CS_SETUP, spi_cs_n low, busy high. pkt_start outside IDLE ignored.
- CS_SETUP: wait CLK_DIV cycles → HDR (header enabled) or FETCH.
- HDR: load 8'hA5, shift; then load seq_num, shift; → FETCH.
- FETCH: buf_rd_en high exactly one cycle → WAIT_VLD.
- WAIT_VLD: on buf_valid, load buf_dout into shift register → SHIFT. No buf_valid within 4 cycles → abort.
- SHIFT: 8 bits out; byte_cnt+1; byte_cnt==PKT_BYTES → CS_HOLD else FETCH.
- CS_HOLD: CLK_DIV cycles, spi_cs_n high, pkt_done pulse, seq_num+1 (wraps 255→0) → GAP.
- GAP: CS_GAP cycles → IDLE, busy low.
- Underrun: buf_rd_out high while byte_cnt<PKT_BYTES-1 at FETCH, or valid timeout → spi_cs_n high next cycle, pkt_err pulse, seq_num unchanged → GAP.
- Byte counter CNT_WIDTH bits, cleared in IDLE; bit counter 3 bits.

## Timing
- Reset values: buf_rd_en 0, spi_sclk 0, spi_cs_n 1, spi_mosi 0, busy 0, pkt_done 0, pkt_err 0, seq_num 0, state IDLE.
- Reset mid-packet: all outputs to reset values on the next edge; packet discarded.
- SCLK: low CLK_DIV cycles, high CLK_DIV cycles per bit. MOSI updates on SCLK falling edge (first bit at CS_SETUP exit); sampled on rising edge.
- spi_sclk held low outside SHIFT/HDR; no SCLK edges during FETCH/WAIT_VLD (byte gap = 4 cycles nominal).
- pkt_start→spi_cs_n low: 1 cycle. Last SCLK falling edge → spi_cs_n high: CLK_DIV cycles.
- Packet period (header on): CLK_DIV + (PKT_BYTES+2)·16·CLK_DIV + PKT_BYTES·4 + CLK_DIV + CS_GAP cycles.

## Configuration
- SPI_PKT_HDR_EN defined: 2-byte header (0xA5, seq_num) precedes payload; seq_num counter present.
- Undefined: HDR state and seq_num removed; CS_SETUP → FETCH directly; frame is payload only.

## Structure
- Package spi_pkt_pkg: state enum, SYNC_BYTE = 8'hA5, VLD_TIMEOUT = 4.
- Sub-module spi_byte_shifter: SCLK divider + 8-bit MSB-first shift register with load/start/done handshake; top holds FSM and counters.

## Test plan
- Reset, pkt_start, buffer model returning 0..59 → SPI slave model captures A5,00,00..3B; one pkt_done; spi_cs_n high after.
- Two back-to-back packets → second header seq 01; CS high ≥CS_GAP cycles between.
- pkt_start pulsed mid-packet → ignored, byte count still 62 (header on).
- buf_rd_out forced high after 30 bytes → spi_cs_n high next cycle, pkt_err pulse, next packet seq unchanged.
- buf_valid withheld → abort after 4 cycles, pkt_err.
- rst asserted at byte 20 → outputs reset values next cycle; new pkt_start sends full packet with seq 00.

Source files
------------

// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the SPI packet transmitter.
package spi_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    HDR      = 3'd2,
    FETCH    = 3'd3,
    WAIT_VLD = 3'd4,
    SHIFT    = 3'd5,
    CS_HOLD  = 3'd6,
    GAP      = 3'd7
  } state_t;

  // First header byte, lets the receiver find the frame start.
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  // Cycles allowed between a read strobe's WAIT_VLD entry and buf_valid.
  localparam int         VLD_TIMEOUT = 4;

endpackage

// File: rtl/spi_byte_shifter.sv
// SCLK divider plus MSB-first shift register for one SPI mode-0 byte.
// A start pulse loads the byte and begins clocking; done pulses for one cycle
// after the eighth falling edge. MOSI changes only while SCLK is low.
module spi_byte_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] sreg;
  logic [15:0]           div_cnt;
  logic [2:0]            bit_cnt;
  logic                  active;

  // Half-period divider; shift on the falling edge so MOSI is stable at the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      done    <= 1'b0;
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sreg    <= din;
        active  <= 1'b1;
        sclk    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (active) begin
        if (div_cnt == 16'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (bit_cnt == 3'(DATA_WIDTH - 1)) begin
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sreg    <= {sreg[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

  assign mosi = sreg[DATA_WIDTH-1];

endmodule

// File: rtl/spi_pkt_tx.sv
// SPI master that drains one packet from the packet buffer per pkt_start.
// Optional feature macro: SPI_PKT_HDR_EN -- when defined, each frame is
// prefixed with SYNC_BYTE and an 8-bit sequence number that advances on
// every successfully sent packet.
module spi_pkt_tx
  import spi_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_BYTES  = 60,
  parameter int CNT_WIDTH  = 14,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_start,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_dout,
  input  logic                  buf_valid,
  input  logic                  buf_rd_out,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  pkt_err
);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic                  rd_en;
  logic                  done_d, err_d;
  logic                  sh_start, sh_done;
  logic [DATA_WIDTH-1:0] sh_data;
  logic                  cs_n_q, busy_q, done_q, err_q;
`ifdef SPI_PKT_HDR_EN
  logic [7:0]            seq_q, seq_d;
  logic                  hdr_sel_q, hdr_sel_d;
`endif

  spi_byte_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .din   (sh_data),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi),
    .done  (sh_done)
  );

  // Next-state, counter and strobe logic for the packet sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    rd_en      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sh_start   = 1'b0;
    sh_data    = buf_dout;
`ifdef SPI_PKT_HDR_EN
    seq_d      = seq_q;
    hdr_sel_d  = hdr_sel_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        byte_cnt_d = '0;
        if (pkt_start) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cnt_d = '0;
`ifdef SPI_PKT_HDR_EN
          sh_start  = 1'b1;
          sh_data   = SYNC_BYTE;
          hdr_sel_d = 1'b0;
          state_d   = HDR;
`else
          state_d   = FETCH;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef SPI_PKT_HDR_EN
      HDR: begin
        if (sh_done) begin
          if (!hdr_sel_q) begin
            sh_start  = 1'b1;
            sh_data   = seq_q;
            hdr_sel_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
`endif
      FETCH: begin
        cnt_d = '0;
        // Buffer claims to be empty before the payload is complete: underrun.
        if (buf_rd_out && (byte_cnt_q < CNT_WIDTH'(PKT_BYTES - 1))) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          rd_en   = 1'b1;
          state_d = WAIT_VLD;
        end
      end
      WAIT_VLD: begin
        if (buf_valid) begin
          sh_start = 1'b1;
          sh_data  = buf_dout;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else if (cnt_q == 16'(VLD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (sh_done) begin
          byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
          cnt_d      = '0;
          if (byte_cnt_d == CNT_WIDTH'(PKT_BYTES)) state_d = CS_HOLD;
          else                                      state_d = FETCH;
        end
      end
      CS_HOLD: begin
        // Entry is already one cycle past the last falling edge, so exit at
        // CLK_DIV-2 to raise chip select CLK_DIV cycles after that edge.
        if (cnt_q >= 16'(CLK_DIV - 2)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
`ifdef SPI_PKT_HDR_EN
          seq_d   = seq_q + 8'd1;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'(CS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SPI_PKT_HDR_EN
      seq_q      <= '0;
      hdr_sel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cs_n_q     <= !(state_d inside {CS_SETUP, HDR, FETCH, WAIT_VLD, SHIFT, CS_HOLD});
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef SPI_PKT_HDR_EN
      seq_q      <= seq_d;
      hdr_sel_q  <= hdr_sel_d;
`endif
    end
  end

  assign buf_rd_en = rd_en;
  assign spi_cs_n  = cs_n_q;
  assign busy      = busy_q;
  assign pkt_done  = done_q;
  assign pkt_err   = err_q;

endmodule
